mem_wb_pipe: RTL and testbench
==============================

# mem_wb_pipe

Parametrised MEM/WB pipeline stage replacing the fixed single-register stage between data-memory access and register-file write-back. It buffers up to DEPTH in-flight results in a circular queue with valid/ready handshakes on both sides, so a variable-latency data memory upstream and a stalling write-back port downstream no longer lose or duplicate instructions. It also supports synchronous flush, suppresses writes to register 0, and precomputes the write-back data mux.

## Interface
Parameters:
- DATA_W, 32, width of memory read data, ALU result and write-back data
- ADDR_W, 5, register-file address width
- DEPTH, 2, queue entries; power of two, at least 2

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous and active-high
- flush  in  1  synchronous kill of all queued entries
- in_valid  in  1  MEM stage presents an entry
- in_ready  out  1  stage can accept an entry this cycle
- in_reg_write  in  1  entry writes the register file
- in_mem_to_reg  in  1  write-back selects memory data, not ALU result
- in_wr_addr  in  ADDR_W  destination register
- in_mem_rdata  in  DATA_W  data-memory read data
- in_alu_result  in  DATA_W  ALU result / memory address
- out_valid  out  1  head entry valid
- out_ready  in  1  WB stage consumes the head this cycle
- out_reg_write  out  1  head control: register write (already zero-suppressed)
- out_mem_to_reg  out  1  head control: memory-to-register
- out_wr_addr  out  ADDR_W  head destination register
- out_mem_rdata  out  DATA_W  head memory data
- out_alu_result  out  DATA_W  head ALU result
- out_wb_data  out  DATA_W  head write-back value
- occupancy  out  clog2(DEPTH+1)  entries currently held

## Operation
- Push occurs when in_valid && in_ready && !flush. Pop occurs when out_valid && out_ready.
- in_ready = (occupancy < DEPTH). It depends only on registered state, never on out_ready, so a full queue cannot accept on the same cycle it pops.
- On push, the entry stores:
  - reg_write = in_reg_write && (in_wr_addr != 0)
  - mem_to_reg, wr_addr, mem_rdata, alu_result as presented
  - wb_data = in_mem_to_reg ? in_mem_rdata : in_alu_result
- Queue order is strict FIFO. wr_ptr and rd_ptr are clog2(DEPTH) bits and wrap modulo DEPTH.
- occupancy changes by +1 on push only, −1 on pop only, and is unchanged on simultaneous push and pop.
- out_valid = (occupancy != 0). All out_* payload outputs are forced to 0 while out_valid=0.
- flush: on the next edge occupancy, wr_ptr and rd_ptr become 0. A same-cycle push is dropped. A same-cycle pop is still a completed transfer downstream, and the entry is then discarded with the rest.
- Upstream must hold the in_* signals stable while in_valid && !in_ready. The block does not check this.

## Timing
- Latency is 1 cycle: an entry pushed at edge N is visible on out_* after edge N. There is no combinational path from in_* to out_*.
- Throughput is one entry per cycle whenever occupancy < DEPTH and downstream is ready.
- Reset (rst high, any time including mid-transfer):
  - occupancy=0, pointers=0
  - out_valid=0, all payload outputs 0
  - in_ready=1
  - no entry survives reset
- Payload storage needs no reset; gating keeps outputs at 0 regardless.
- Full boundary: occupancy=DEPTH → in_ready=0 until after the edge of the first pop.
- Empty boundary: out_ready is ignored while out_valid=0. Occupancy never underflows.

## Structure
- Shared package pipeline_pkg holds DATA_W=32, REG_ADDR_W=5, ZERO_REG=0, and the entry field order/width constants (entry width = 2 + ADDR_W + 3·DATA_W). These are shared with the IF/ID, ID/EX and EX/MEM stages.
- One sub-module, pipe_fifo:
  - generic DEPTH×WIDTH circular buffer holding pointers, occupancy and storage
  - mem_wb_pipe packs and unpacks entries and applies the zero-register and write-back mux logic
  - pipe_fifo is reusable by the other pipeline stages

## Test plan
- Reset, then a single push {reg_write=1, mem_to_reg=1, wr_addr=5, mem_rdata=0xDEADBEEF, alu=0x10} with out_ready=1 → one cycle later out_valid=1, out_wb_data=0xDEADBEEF, out_wr_addr=5; occupancy returns to 0 after the pop.
- Push wr_addr=0 with reg_write=1 and mem_to_reg=0, alu=0x1234 → out_reg_write=0, out_wb_data=0x1234.
- out_ready=0 and push 3 entries (A, B, C) with DEPTH=2 → A and B accepted, in_ready=0 while C is held, occupancy=2; then raise out_ready → pops come out in order A, B, C with no loss or duplication.
- Continuous push with out_ready=1 for 8 cycles → 8 pops in order, occupancy stays at 1, pointers wrap 4 times.
- Occupancy=2 with flush asserted together with in_valid=1 → next cycle occupancy=0, out_valid=0, and the pushed entry never appears.
- Assert rst mid-stream with occupancy=1 → immediately out_valid=0, payload outputs 0, in_ready=1; after rst deasserts, the first pop is the first post-reset push.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Constants shared by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline stages.
// MEM/WB entry layout, MSB to LSB: reg_write, mem_to_reg, wr_addr, mem_rdata, alu_result, wb_data.
package pipeline_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ZERO_REG   = 0;

  localparam int CTRL_W     = 2;
  localparam int DATA_WORDS = 3;

  function automatic int entry_width(input int addr_w, input int data_w);
    return CTRL_W + addr_w + DATA_WORDS * data_w;
  endfunction

  localparam int MEM_WB_ENTRY_W = entry_width(REG_ADDR_W, DATA_W);

endpackage

// File: rtl/mem_wb_pipe_if.sv
// MEM/WB boundary bundle: upstream push side, downstream pop side and flush.
// The master modport belongs to the surrounding pipeline, and the slave modport belongs to the stage.
interface mem_wb_pipe_if #(
  parameter int DATA_W = pipeline_pkg::DATA_W,
  parameter int ADDR_W = pipeline_pkg::REG_ADDR_W
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              in_reg_write;
  logic              in_mem_to_reg;
  logic [ADDR_W-1:0] in_wr_addr;
  logic [DATA_W-1:0] in_mem_rdata;
  logic [DATA_W-1:0] in_alu_result;
  logic              out_valid;
  logic              out_ready;
  logic              out_reg_write;
  logic              out_mem_to_reg;
  logic [ADDR_W-1:0] out_wr_addr;
  logic [DATA_W-1:0] out_mem_rdata;
  logic [DATA_W-1:0] out_alu_result;
  logic [DATA_W-1:0] out_wb_data;

  modport master (
    output flush, in_valid, in_reg_write, in_mem_to_reg, in_wr_addr, in_mem_rdata,
           in_alu_result, out_ready,
    input  in_ready, out_valid, out_reg_write, out_mem_to_reg, out_wr_addr,
           out_mem_rdata, out_alu_result, out_wb_data
  );

  modport slave (
    input  flush, in_valid, in_reg_write, in_mem_to_reg, in_wr_addr, in_mem_rdata,
           in_alu_result, out_ready,
    output in_ready, out_valid, out_reg_write, out_mem_to_reg, out_wr_addr,
           out_mem_rdata, out_alu_result, out_wb_data
  );
endinterface

// File: rtl/pipe_fifo.sv
// Generic DEPTH x WIDTH circular queue with registered occupancy and synchronous flush.
// Acceptance depends only on registered state, so a full queue never accepts on the cycle it pops.
module pipe_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         not_full_o,
  output logic                         not_empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             do_push;
  logic             do_pop;

  assign not_full_o  = (occ_q < OCC_W'(DEPTH));
  assign not_empty_o = (occ_q != '0);
  assign do_push     = push_i && not_full_o && !flush_i;
  assign do_pop      = pop_i && not_empty_o;
  assign occupancy_o = occ_q;
  assign rdata_o     = mem_q[rd_ptr_q];

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // NOTE: storage is deliberately not reset; consumers gate it with not_empty_o.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB stage: an elastic queue of in-flight results with register-0 write suppression
// and a write-back data mux that is evaluated before the entry is stored.
module mem_wb_pipe #(
  parameter int DATA_W = pipeline_pkg::DATA_W,
  parameter int ADDR_W = pipeline_pkg::REG_ADDR_W,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  mem_wb_pipe_if.slave               bus,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  import pipeline_pkg::*;

  localparam int PKT_W = entry_width(ADDR_W, DATA_W);

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] wb_data;
  } entry_t;

  entry_t             push_entry;
  entry_t             head_entry;
  logic [PKT_W-1:0]   head_bits;
  logic               head_valid;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    push_entry            = '0;
    push_entry.reg_write  = bus.in_reg_write && (bus.in_wr_addr != ADDR_W'(ZERO_REG));
    push_entry.mem_to_reg = bus.in_mem_to_reg;
    push_entry.wr_addr    = bus.in_wr_addr;
    push_entry.mem_rdata  = bus.in_mem_rdata;
    push_entry.alu_result = bus.in_alu_result;
    push_entry.wb_data    = bus.in_mem_to_reg ? bus.in_mem_rdata : bus.in_alu_result;
  end

  pipe_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (bus.flush),
    .push_i      (bus.in_valid),
    .pop_i       (bus.out_ready),
    .wdata_i     (push_entry),
    .rdata_o     (head_bits),
    .not_full_o  (bus.in_ready),
    .not_empty_o (head_valid),
    .occupancy_o (occupancy)
  );

  assign head_entry = entry_t'(head_bits);

  // Unreset storage never reaches the ports: the payload reads as zero while the queue is empty.
  assign bus.out_valid      = head_valid;
  assign bus.out_reg_write  = head_valid ? head_entry.reg_write  : 1'b0;
  assign bus.out_mem_to_reg = head_valid ? head_entry.mem_to_reg : 1'b0;
  assign bus.out_wr_addr    = head_valid ? head_entry.wr_addr    : '0;
  assign bus.out_mem_rdata  = head_valid ? head_entry.mem_rdata  : '0;
  assign bus.out_alu_result = head_valid ? head_entry.alu_result : '0;
  assign bus.out_wb_data    = head_valid ? head_entry.wb_data    : '0;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed scoreboard bench for mem_wb_pipe with DEPTH=2: entries expected at the output are queued
// when driven, then popped and compared when the stage hands them to write-back.
module tb_mem_wb_pipe;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;

  typedef struct {
    logic          rw;
    logic          m2r;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
    logic [DW-1:0] alu;
    logic [DW-1:0] wb;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] occupancy;
  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  mem_wb_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_wb_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .occupancy (occupancy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_payload(input string tag);
    chk({tag, "_rw"},    32'(bus.out_reg_write),  32'd0);
    chk({tag, "_m2r"},   32'(bus.out_mem_to_reg), 32'd0);
    chk({tag, "_addr"},  32'(bus.out_wr_addr),    32'd0);
    chk({tag, "_rdata"}, bus.out_mem_rdata,       32'd0);
    chk({tag, "_alu"},   bus.out_alu_result,      32'd0);
    chk({tag, "_wb"},    bus.out_wb_data,         32'd0);
  endtask

  // One cycle: drive at the falling edge, check 1 ns later, update the model, and advance to the next falling edge.
  task automatic step(input logic v, input logic rw, input logic m2r, input logic [AW-1:0] a,
                      input logic [DW-1:0] rd, input logic [DW-1:0] alu,
                      input logic ordy, input logic fl);
    bit   rdy_exp;
    exp_t e;
    bus.in_valid      = v;
    bus.in_reg_write  = rw;
    bus.in_mem_to_reg = m2r;
    bus.in_wr_addr    = a;
    bus.in_mem_rdata  = rd;
    bus.in_alu_result = alu;
    bus.out_ready     = ordy;
    bus.flush         = fl;
    #1;
    rdy_exp = (sb.size() < DEPTH);
    chk("occupancy", 32'(occupancy),     32'(sb.size()));
    chk("in_ready",  32'(bus.in_ready),  32'(rdy_exp));
    chk("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
    if (sb.size() == 0) begin
      chk_idle_payload("idle");
    end else if (ordy) begin
      e = sb.pop_front();
      chk("out_reg_write",  32'(bus.out_reg_write),  32'(e.rw));
      chk("out_mem_to_reg", 32'(bus.out_mem_to_reg), 32'(e.m2r));
      chk("out_wr_addr",    32'(bus.out_wr_addr),    32'(e.addr));
      chk("out_mem_rdata",  bus.out_mem_rdata,       e.rdata);
      chk("out_alu_result", bus.out_alu_result,      e.alu);
      chk("out_wb_data",    bus.out_wb_data,         e.wb);
    end
    if (fl) begin
      sb.delete();
    end else if (v && rdy_exp) begin
      e.rw    = rw && (a != '0);
      e.m2r   = m2r;
      e.addr  = a;
      e.rdata = rd;
      e.alu   = alu;
      e.wb    = m2r ? rd : alu;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, ordy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_reg_write = 1'b0; bus.in_mem_to_reg = 1'b0;
    bus.in_wr_addr = '0; bus.in_mem_rdata = '0; bus.in_alu_result = '0; bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_occupancy", 32'(occupancy),     32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk_idle_payload("rst");
    rst = 1'b0;
    @(negedge clk);

    // Single load-word style push, then drain; out_ready is held high while empty.
    step(1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 32'h10, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Write to register 0 is suppressed, and the ALU result is selected.
    step(1'b1, 1'b1, 1'b0, 5'd0, 32'hAAAA5555, 32'h1234, 1'b1, 1'b0);
    idle(1'b1);

    // Backpressure: A and B fill the queue, and C is held until a slot frees.
    step(1'b1, 1'b1, 1'b0, 5'd1, 32'h0000000A, 32'hA0A0A0A0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 5'd2, 32'h0000000B, 32'hB0B0B0B0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 5'd3, 32'h0000000C, 32'hC0C0C0C0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 5'd3, 32'h0000000C, 32'hC0C0C0C0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 5'd3, 32'h0000000C, 32'hC0C0C0C0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Streaming: one push and one pop per cycle, so the pointers wrap repeatedly.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom, 1'b1, 1'b0);
    end
    idle(1'b1);
    idle(1'b1);

    // Flush while full with a colliding push: the push is dropped and the queue empties.
    step(1'b1, 1'b1, 1'b0, 5'd7, 32'h11111111, 32'h22222222, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 5'd8, 32'h33333333, 32'h44444444, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 5'd9, 32'h55555555, 32'h66666666, 1'b0, 1'b1);
    idle(1'b1);

    // Flush with a same-cycle pop: the head still transfers, and the rest is discarded.
    step(1'b1, 1'b1, 1'b0, 5'd10, 32'h77777777, 32'h88888888, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 5'd11, 32'h99999999, 32'hAAAAAAAA, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b1);
    idle(1'b1);

    // Asynchronous reset mid-stream: the outputs clear at once, and the first post-reset push comes out first.
    step(1'b1, 1'b1, 1'b1, 5'd12, 32'hCAFEF00D, 32'hBBBBBBBB, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_occupancy", 32'(occupancy),     32'd0);
    chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk_idle_payload("mid_rst");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 5'd13, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
